// File: rtl/fifo_rd_packer.sv
// Packs WIDTH-bit bytes read from a FIFO read port into LANES-wide words with a
// per-lane keep mask; flush closes a partial word, err latches read-side faults.
module fifo_rd_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                     rd_clk,
  input  logic                     rst_n,
  output logic                     rd_en,
  input  logic [WIDTH-1:0]         rdata,
  input  logic                     empty,
  input  logic                     underflow,
  input  logic                     flush,
  output logic [WIDTH*LANES-1:0]   m_data,
  output logic [LANES-1:0]         m_keep,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     err
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned CW = LW + 1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 fcnt_q, fcnt_d;
  logic                          pend_q;
  logic [LANES-1:0][WIDTH-1:0]   asm_q, asm_d, asm_nxt_c;
  logic [WIDTH-1:0]              carry_q, carry_d;
  logic                          carry_v_q, carry_v_d;
  logic [WIDTH*LANES-1:0]        out_data_q, out_data_d;
  logic [LANES-1:0]              out_keep_q, out_keep_d;
  logic                          out_valid_q, out_valid_d;
  logic                          err_q, err_d;
  logic [CW-1:0]                 fill_c;
  logic                          out_free_c;
  logic                          close_c;

  function automatic logic [LANES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LANES; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  // Bytes owned by the assembly word: captured ones plus the one arriving now.
  assign fill_c     = fcnt_q + CW'(pend_q);
  assign out_free_c = !out_valid_q || m_ready;
  assign rd_en      = !empty && (state_q == COLLECT) && (fill_c < CW'(LANES));

  assign m_data  = out_data_q;
  assign m_keep  = out_keep_q;
  assign m_valid = out_valid_q;
  assign err     = err_q;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    asm_d       = asm_q;
    asm_nxt_c   = asm_q;
    carry_d     = carry_q;
    carry_v_d   = carry_v_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q && !m_ready;
    err_d       = err_q || underflow || (rd_en && empty);
    close_c     = 1'b0;

    if (pend_q) asm_nxt_c[fcnt_q[LW-1:0]] = rdata;

    unique case (state_q)
      COLLECT: begin
        close_c = (fill_c == CW'(LANES)) || (flush && (fill_c != '0));
        asm_d   = asm_nxt_c;
        fcnt_d  = fill_c;
        if (close_c) begin
          if (out_free_c) begin
            out_data_d  = asm_nxt_c;
            out_keep_d  = keep_mask(fill_c);
            out_valid_d = 1'b1;
            fcnt_d      = '0;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A read issued in the closing cycle lands here; park it for the next word.
        if (pend_q) begin
          carry_d   = rdata;
          carry_v_d = 1'b1;
        end
        if (m_ready) begin
          out_data_d  = asm_q;
          out_keep_d  = keep_mask(fcnt_q);
          out_valid_d = 1'b1;
          state_d     = COLLECT;
          fcnt_d      = CW'(pend_q || carry_v_q);
          asm_d[0]    = pend_q ? rdata : carry_q;
          carry_v_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      fcnt_q      <= '0;
      pend_q      <= 1'b0;
      asm_q       <= '0;
      carry_q     <= '0;
      carry_v_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= rd_en;
      asm_q       <= asm_d;
      carry_q     <= carry_d;
      carry_v_q   <= carry_v_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a FIFO model feeds bytes, a byte-stream
// reference model predicts words, a negedge monitor checks each transfer.
module tb_fifo_rd_packer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LANES = 4;

  typedef struct packed {
    logic [WIDTH*LANES-1:0] data;
    logic [LANES-1:0]       keep;
  } word_t;

  logic                   clk;
  logic                   rst_n;
  logic                   rd_en;
  logic [WIDTH-1:0]       rdata;
  logic                   empty;
  logic                   underflow;
  logic                   flush;
  logic [WIDTH*LANES-1:0] m_data;
  logic [LANES-1:0]       m_keep;
  logic                   m_valid;
  logic                   m_ready;
  logic                   err;

  fifo_rd_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .rd_clk    (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .empty     (empty),
    .underflow (underflow),
    .flush     (flush),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err       (err)
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] cur_b[$];
  word_t            exp_q[$];
  logic [WIDTH-1:0] rd_stage;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_rd   = 0;
  int n_vld  = 0;
  int n_xfer = 0;
  int first_rd_cyc   = 0;
  int last_xfer_cyc  = 0;
  int prev_xfer_cyc  = 0;
  logic rd_seen      = 1'b0;
  logic [WIDTH*LANES-1:0] last_data = '0;
  logic [LANES-1:0]       last_keep = '0;
  logic                   hold_prev = 1'b0;
  logic [WIDTH*LANES-1:0] hold_data = '0;
  logic [LANES-1:0]       hold_keep = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a word is the bytes read since the last close, lane i = i-th byte.
  task automatic close_word();
    word_t w;
    w = '0;
    for (int i = 0; i < cur_b.size(); i++)
      w.data = w.data | ((WIDTH*LANES)'(cur_b[i]) << (WIDTH * i));
    w.keep = LANES'((1 << cur_b.size()) - 1);
    exp_q.push_back(w);
    cur_b.delete();
  endtask

  // FIFO model: data appears the cycle after an accepted read.
  initial begin
    empty = 1'b1;
    rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      rdata = rd_stage;
      empty = (fifo_q.size() == 0);
    end
  end

  // Monitor, then reference model, both evaluated mid-cycle.
  always @(negedge clk) begin
    word_t e;
    logic [WIDTH*LANES-1:0] mask;
    cyc++;
    if (!rst_n) begin
      cur_b.delete();
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(hold_data));
        chk("hold_keep", 64'(m_keep), 64'(hold_keep));
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
      hold_keep = m_keep;
      if (m_valid) n_vld++;
      if (m_valid && m_ready) begin
        n_xfer++;
        prev_xfer_cyc = last_xfer_cyc;
        last_xfer_cyc = cyc;
        last_data = m_data;
        last_keep = m_keep;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(m_data), 64'd0);
          if (m_data == '0) begin
            n_fail++;
            $display("FAIL unexpected_word: got word with keep %0h expected none", m_keep);
          end
        end else begin
          e = exp_q.pop_front();
          mask = '0;
          for (int i = 0; i < LANES; i++)
            if (e.keep[i]) mask[WIDTH*i +: WIDTH] = '1;
          chk("word_keep", 64'(m_keep), 64'(e.keep));
          chk("word_data", 64'(m_data & mask), 64'(e.data & mask));
        end
      end
      if (flush && cur_b.size() > 0) close_word();
      if (rd_en) begin
        n_rd++;
        if (!rd_seen) begin
          rd_seen = 1'b1;
          first_rd_cyc = cyc;
        end
        if (fifo_q.size() == 0) begin
          chk("rd_en_when_empty", 64'd1, 64'd0);
        end else begin
          rd_stage = fifo_q.pop_front();
          cur_b.push_back(rd_stage);
          if (cur_b.size() == LANES) close_word();
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  int rd0, v0, x0;

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; underflow = 1'b0; rd_stage = '0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_keep", 64'(m_keep), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single full word with latency and read count
    m_ready = 1'b1;
    rd_seen = 1'b0; rd0 = n_rd; v0 = n_vld; x0 = n_xfer;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    tick(10);
    chk("t1_rd_cycles", 64'(n_rd - rd0), 64'd4);
    chk("t1_valid_cycles", 64'(n_vld - v0), 64'd1);
    chk("t1_xfers", 64'(n_xfer - x0), 64'd1);
    chk("t1_data", 64'(last_data), 64'h44332211);
    chk("t1_keep", 64'(last_keep), 64'hF);
    chk("t1_latency", 64'(last_xfer_cyc - first_rd_cyc), 64'(LANES + 1));

    // Backpressure: two words, second parked while first is stalled
    m_ready = 1'b0;
    rd0 = n_rd; x0 = n_xfer;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    tick(14);
    chk("t2_rd_en_low", 64'(rd_en), 64'd0);
    chk("t2_reads", 64'(n_rd - rd0), 64'd8);
    chk("t2_valid", 64'(m_valid), 64'd1);
    chk("t2_data", 64'(m_data), 64'h04030201);
    chk("t2_keep", 64'(m_keep), 64'hF);
    m_ready = 1'b1;
    tick(5);
    chk("t2_xfers", 64'(n_xfer - x0), 64'd2);
    chk("t2_back_to_back", 64'(last_xfer_cyc - prev_xfer_cyc), 64'd1);
    chk("t2_last_data", 64'(last_data), 64'h08070605);

    // Flush of a three-byte partial word
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB); fifo_q.push_back(8'hCC);
    tick(6);
    pulse_flush();
    tick(3);
    chk("t3_keep", 64'(last_keep), 64'h7);
    chk("t3_data", 64'(last_data[23:0]), 64'hCCBBAA);

    // Flush while the second byte is still pending
    fifo_q.push_back(8'h5A); fifo_q.push_back(8'hA5);
    tick(2);
    pulse_flush();
    tick(4);
    chk("t4_keep", 64'(last_keep), 64'h3);
    chk("t4_data", 64'(last_data[15:0]), 64'hA55A);
    v0 = n_vld;
    pulse_flush();
    tick(5);
    chk("t4_empty_flush_no_valid", 64'(n_vld - v0), 64'd0);

    // Random backpressure, no flush
    for (int c = 0; c < 600; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
      tick(1);
    end
    m_ready = 1'b1;
    tick(4);

    // Random flushes with the sink always ready
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) fifo_q.push_back(8'($urandom));
      tick(1);
    end
    flush = 1'b0;
    tick(10);
    pulse_flush();
    tick(10);
    chk("rand_words_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
    chk("rand_err_clear", 64'(err), 64'd0);

    // Sticky error
    underflow = 1'b1;
    tick(1);
    underflow = 1'b0;
    tick(3);
    chk("err_set", 64'(err), 64'd1);
    tick(20);
    chk("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset mid-word with an occupied output
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hC0 + 8'(i));
    tick(9);
    chk("t7_pre_valid", 64'(m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 64'(m_valid), 64'd0);
    chk("t7_data", 64'(m_data), 64'd0);
    chk("t7_keep", 64'(m_keep), 64'd0);
    chk("t7_err", 64'(err), 64'd0);
    chk("t7_rd_en", 64'(rd_en), 64'd0);
    tick(1);
    rst_n = 1'b1;
    m_ready = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + 8'(i));
    tick(12);
    chk("t7_post_xfers", 64'(n_xfer - x0), 64'd1);
    chk("t7_post_data", 64'(last_data), 64'hA3A2A1A0);
    chk("t7_post_keep", 64'(last_keep), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
